pwm_duty_sched: RTL and testbench

//  Soft-start/soft-stop scheduler for one pwm_42 channel: drives the channel's 9-bit duty D and enable E.

---
 rtl/pwm_duty_sched.sv | 160 ++++++++++++++++
 tb/tb_pwm_duty_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sched.sv
// Soft-start/soft-stop duty scheduler for one pwm_42 channel: ramps duty D toward TARGET
// in bounded steps at PWM period boundaries, mirrors the channel period counter, latches faults.
module pwm_duty_sched #(
    parameter int PERIOD   = 510,
    parameter int DMAX     = 510,
    parameter int STEP     = 4,
    parameter int RAMP_DIV = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RUN,
    input  logic [8:0] TARGET,
    input  logic       FAULT_IN,
    input  logic       FAULT_CLR,
    output logic [8:0] D,
    output logic       E,
    output logic       PER_TICK,
    output logic       AT_TARGET,
    output logic       BUSY,
    output logic       FAULT_O
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RAMP  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam int          DW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [8:0]  CNT_LAST = 9'(PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);
    localparam logic [8:0]  DMAX_V   = 9'(DMAX);
    localparam logic [9:0]  STEP_W   = 10'(STEP);
    localparam logic [8:0]  STEP_N   = 9'(STEP);

    logic [2:0]    state, state_n;
    logic [8:0]    d, d_n;
    logic          e, e_n;
    logic [8:0]    cnt, cnt_n;
    logic [DW-1:0] div, div_n;
    logic [8:0]    tgt, tgt_n;

    logic          boundary, upd;
    logic [8:0]    tgt_in, floor_v, ramp_v;
    logic [9:0]    sum_up, floor_plus;

    assign boundary = e && (cnt == CNT_LAST);
    assign upd      = boundary && (div == DIV_LAST);
    assign tgt_in   = (TARGET > DMAX_V) ? DMAX_V : TARGET;

    // Ramp step evaluated 10 bits wide so it saturates at the floor/target instead of wrapping.
    always_comb begin
        floor_v    = (state == S_STOP) ? '0 : tgt;
        sum_up     = {1'b0, d} + STEP_W;
        floor_plus = {1'b0, floor_v} + STEP_W;
        if (state == S_RAMP && d < tgt)
            ramp_v = (sum_up >= {1'b0, tgt}) ? tgt : d + STEP_N;
        else
            ramp_v = ({1'b0, d} <= floor_plus) ? floor_v : d - STEP_N;
    end

    always_comb begin
        state_n = state;
        d_n     = d;
        e_n     = e;
        cnt_n   = cnt;
        div_n   = div;
        tgt_n   = tgt;
        if (e)
            cnt_n = (cnt == CNT_LAST) ? '0 : cnt + 9'd1;
        if (boundary) begin
            tgt_n = tgt_in;
            div_n = (div == DIV_LAST) ? '0 : div + 1'b1;
        end
        if (FAULT_IN) begin
            state_n = S_FAULT;
            d_n     = '0;
            e_n     = 1'b0;
            cnt_n   = '0;
            div_n   = '0;
            tgt_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    d_n   = '0;
                    e_n   = 1'b0;
                    cnt_n = '0;
                    div_n = '0;
                    if (RUN) begin
                        state_n = S_RAMP;
                        e_n     = 1'b1;
                        tgt_n   = tgt_in;
                    end
                end
                S_RAMP: begin
                    if (!RUN)
                        state_n = S_STOP;
                    else if (boundary && d == tgt)
                        state_n = S_HOLD;
                    else if (upd)
                        d_n = ramp_v;
                end
                S_HOLD: begin
                    if (!RUN)
                        state_n = S_STOP;
                    else if (boundary && tgt_in != d) begin
                        state_n = S_RAMP;
                        div_n   = '0;
                    end
                end
                S_STOP: begin
                    if (RUN)
                        state_n = S_RAMP;
                    else if (boundary && d == '0) begin
                        state_n = S_IDLE;
                        e_n     = 1'b0;
                        cnt_n   = '0;
                        div_n   = '0;
                    end else if (upd)
                        d_n = ramp_v;
                end
                S_FAULT: begin
                    d_n   = '0;
                    e_n   = 1'b0;
                    cnt_n = '0;
                    div_n = '0;
                    if (FAULT_CLR && !RUN)
                        state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            d     <= '0;
            e     <= 1'b0;
            cnt   <= '0;
            div   <= '0;
            tgt   <= '0;
        end else begin
            state <= state_n;
            d     <= d_n;
            e     <= e_n;
            cnt   <= cnt_n;
            div   <= div_n;
            tgt   <= tgt_n;
        end
    end

    assign D         = d;
    assign E         = e;
    assign PER_TICK  = boundary;
    assign AT_TARGET = (state == S_HOLD);
    assign BUSY      = (state == S_RAMP) || (state == S_STOP);
    assign FAULT_O   = (state == S_FAULT);

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Bench for pwm_duty_sched: directed soft-start/stop/fault/reset scenarios, then random stimulus,
// all outputs compared every cycle against a behavioural model of the scheduler.
module tb_pwm_duty_sched;

    localparam int PERIOD   = 40;
    localparam int DMAX     = 38;
    localparam int STEP     = 4;
    localparam int RAMP_DIV = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [8:0] target;
    logic       fault_in;
    logic       fault_clr;
    logic [8:0] d;
    logic       e, tick, at_target, busy, fault_o;

    int checks = 0;
    int errors = 0;
    int trk_min = 511;

    pwm_duty_sched #(.PERIOD(PERIOD), .DMAX(DMAX), .STEP(STEP), .RAMP_DIV(RAMP_DIV)) dut (
        .CLK(clk), .RST_N(rst_n), .RUN(run), .TARGET(target),
        .FAULT_IN(fault_in), .FAULT_CLR(fault_clr),
        .D(d), .E(e), .PER_TICK(tick), .AT_TARGET(at_target), .BUSY(busy), .FAULT_O(fault_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_RAMP, M_HOLD, M_STOP, M_FAULT} mode_t;
    typedef struct {
        mode_t m;
        int    d;
        int    tgt;
        int    age;   // cycles since the enable rose
        int    nb;    // boundaries since the divider last restarted
        bit    en;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.m = M_IDLE; s.d = 0; s.tgt = 0; s.age = 0; s.nb = 0; s.en = 0;
        return s;
    endfunction

    function automatic int toward(int x, int g);
        if (x < g) return (x + STEP > g) ? g : x + STEP;
        return (x - STEP < g) ? g : x - STEP;
    endfunction

    function automatic bit is_bnd(mdl_t s);
        return s.en && (s.age % PERIOD == PERIOD - 1);
    endfunction

    function automatic mdl_t model_next(mdl_t s, bit r, int t, bit fi, bit fc);
        mdl_t n = s;
        bit bnd = is_bnd(s);
        bit up  = bnd && (s.nb % RAMP_DIV == RAMP_DIV - 1);
        int ct  = (t > DMAX) ? DMAX : t;
        if (s.en) n.age = s.age + 1;
        if (bnd) begin n.nb = s.nb + 1; n.tgt = ct; end
        if (fi) begin
            n.m = M_FAULT; n.d = 0; n.en = 0; n.age = 0; n.nb = 0;
        end else begin
            case (s.m)
                M_IDLE:  if (r) begin n.m = M_RAMP; n.en = 1; n.age = 0; n.nb = 0; n.d = 0; n.tgt = ct; end
                M_RAMP:  if (!r) n.m = M_STOP;
                         else if (bnd && s.d == s.tgt) n.m = M_HOLD;
                         else if (up) n.d = toward(s.d, s.tgt);
                M_HOLD:  if (!r) n.m = M_STOP;
                         else if (bnd && ct != s.d) begin n.m = M_RAMP; n.nb = 0; end
                M_STOP:  if (r) n.m = M_RAMP;
                         else if (bnd && s.d == 0) begin n.m = M_IDLE; n.en = 0; n.age = 0; n.nb = 0; end
                         else if (up) n.d = toward(s.d, 0);
                default: if (fc && !r) n.m = M_IDLE;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= mdl_reset();
        else        mdl <= model_next(mdl, run, int'(target), fault_in, fault_clr);
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle model compare plus observed-PWM properties (duty frozen within a period,
    // high count per period equals D).
    initial begin : compare
        int prev_d = 0;
        bit prev_tick = 0;
        int ecyc = 0;
        int hcnt = 0;
        int ex_d;
        bit ex_e, ex_tick, ex_at, ex_busy, ex_flt;
        forever begin
            @(negedge clk);
            ex_d    = mdl.d;
            ex_e    = mdl.en;
            ex_tick = is_bnd(mdl);
            ex_at   = (mdl.m == M_HOLD);
            ex_busy = (mdl.m == M_RAMP) || (mdl.m == M_STOP);
            ex_flt  = (mdl.m == M_FAULT);
            checks++;
            if (int'(d) != ex_d || e !== ex_e || tick !== ex_tick || at_target !== ex_at ||
                busy !== ex_busy || fault_o !== ex_flt) begin
                errors++;
                $display("FAIL outputs t=%0t: D=%0d E=%b TICK=%b AT=%b BUSY=%b FLT=%b, expected D=%0d E=%b TICK=%b AT=%b BUSY=%b FLT=%b",
                         $time, d, e, tick, at_target, busy, fault_o, ex_d, ex_e, ex_tick, ex_at, ex_busy, ex_flt);
            end
            if (int'(d) != prev_d)
                chk("d_changes_only_at_boundary", int'(prev_tick || (d == 9'd0 && !e)), 1);
            if (!e) begin
                ecyc = 0;
                hcnt = 0;
            end else begin
                if ((ecyc % PERIOD) < int'(d)) hcnt++;
                if (tick) begin
                    chk("pwm_high_count", hcnt, int'(d));
                    hcnt = 0;
                end
                ecyc++;
            end
            if (int'(d) < trk_min) trk_min = int'(d);
            prev_d    = int'(d);
            prev_tick = tick;
        end
    end

    task automatic wait_at(input bit want, input int maxc, input string name);
        int c = 0;
        while (at_target !== want && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk(name, int'(at_target), int'(want));
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int seq[8];
        int n, last, first_c, maxd, c;
        bit done, prev_tz;
        int exp_up[5]   = '{4, 8, 12, 16, 20};
        int exp_down[3] = '{6, 2, 0};

        rst_n = 1'b0; run = 1'b0; target = '0; fault_in = 1'b0; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_D", int'(d), 0);
        chk("reset_E", int'(e), 0);
        chk("reset_flags", int'({tick, at_target, busy, fault_o}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_E", int'(e), 0);

        // soft start to 20
        target = 9'd20; run = 1'b1;
        @(negedge clk);
        chk("run_to_E_latency", int'(e), 1);
        chk("ramp_busy", int'(busy), 1);
        n = 0; last = 0; first_c = -1; maxd = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (int'(d) > maxd) maxd = int'(d);
            if (int'(d) != last) begin
                if (n < 8) seq[n] = int'(d);
                n++;
                if (first_c < 0) first_c = i;
                last = int'(d);
            end
            if (at_target) break;
        end
        chk("first_step_latency", first_c, RAMP_DIV * PERIOD);
        chk("up_step_count", n, 5);
        for (int i = 0; i < 5; i++) chk("up_seq", seq[i], exp_up[i]);
        chk("up_hold", int'(at_target), 1);
        chk("up_no_overshoot", maxd, 20);

        // clamp and mid-period retarget
        target = 9'd511;
        wait_at(1'b0, 200, "clamp_leave_hold");
        wait_at(1'b1, 3000, "clamp_reach_hold");
        chk("clamp_D", int'(d), DMAX);
        c = 0;
        while (!tick && c < 200) begin @(negedge clk); c++; end
        chk("tick_seen", int'(tick), 1);
        repeat (5) @(negedge clk);
        target = 9'd6;
        repeat (3) @(negedge clk);
        chk("midperiod_target_ignored_hold", int'(at_target), 1);
        chk("midperiod_target_ignored_D", int'(d), DMAX);
        trk_min = 511;
        wait_at(1'b0, 200, "down_leave_hold");
        wait_at(1'b1, 3000, "down_reach_hold");
        chk("down_final_D", int'(d), 6);
        chk("down_no_undershoot", trk_min, 6);

        // soft stop from 10
        target = 9'd10;
        wait_at(1'b0, 200, "ten_leave_hold");
        wait_at(1'b1, 3000, "ten_reach_hold");
        chk("ten_D", int'(d), 10);
        run = 1'b0;
        @(negedge clk);
        chk("stop_busy", int'(busy), 1);
        chk("stop_not_at_target", int'(at_target), 0);
        n = 0; last = 10; done = 0; prev_tz = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (prev_tz) begin
                chk("stop_E_drop", int'(e), 0);
                done = 1;
                break;
            end
            if (int'(d) != last) begin
                if (n < 8) seq[n] = int'(d);
                n++;
                last = int'(d);
            end
            prev_tz = tick && (d == 9'd0);
        end
        chk("stop_completed", int'(done), 1);
        chk("stop_step_count", n, 3);
        for (int i = 0; i < 3; i++) chk("stop_seq", seq[i], exp_down[i]);

        // fault latch and release rules
        run = 1'b1; target = 9'd30;
        repeat (100) @(negedge clk);
        chk("pre_fault_busy", int'(busy), 1);
        fault_in = 1'b1;
        @(negedge clk);
        fault_in = 1'b0;
        chk("fault_D", int'(d), 0);
        chk("fault_E", int'(e), 0);
        chk("fault_flag", int'(fault_o), 1);
        fault_clr = 1'b1;
        @(negedge clk);
        chk("fault_clr_with_run_stays", int'(fault_o), 1);
        run = 1'b0;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("fault_release", int'(fault_o), 0);
        chk("fault_release_idle", int'({e, busy, at_target}), 0);

        // asynchronous reset mid-ramp
        run = 1'b1; target = 9'd38;
        c = 0;
        while (d < 9'd20 && c < 2000) begin @(negedge clk); c++; end
        chk("pre_reset_D", int'(d >= 9'd20), 1);
        #2 rst_n = 1'b0; run = 1'b0;
        #1;
        chk("async_reset_D", int'(d), 0);
        chk("async_reset_E_busy", int'({e, busy}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_idle", int'({e, busy, at_target, fault_o}), 0);

        // randomized operation
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) run = ~run;
            if ($urandom_range(0, 59) == 0)
                target = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 45)) : 9'($urandom_range(0, 511));
            fault_in  = ($urandom_range(0, 2999) == 0);
            fault_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9999) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        fault_in = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
